// File: rtl/ttt_pkg.sv
// Shared types for the tic-tac-toe move-entry path: board vectors, cell index
// and the move-entry state encoding.
package ttt_pkg;

  localparam int NUM_CELLS = 9;

  typedef logic [NUM_CELLS-1:0] board_t;
  typedef logic [3:0]           cell_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    RELEASE
  } entry_state_t;

  // One-hot cell mask; indices beyond the board give an all-zero mask.
  function automatic board_t cell_onehot(input cell_idx_t idx);
    return board_t'(1) << idx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus counter debounce for the raw keypad press level;
// emits single-cycle pulses on accepted press and release transitions.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic key_press,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          settle;

  // cnt holds the number of earlier consecutive samples that disagreed with
  // level, so the current sample is the DEBOUNCE_CYCLES-th when cnt hits LAST.
  assign settle        = (sync2 != level) && (cnt == CNT_LAST);
  assign press_pulse   = settle &&  sync2;
  assign release_pulse = settle && !sync2;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
  // which is what makes sync1 -> sync2 a real two-stage synchroniser.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= key_press;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (settle) begin
        cnt   <= '0;
        level <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_entry.sv
// Keypad-to-core move entry: debounced press -> legality check -> one-hot xin
// with a Go burst, held until the core acknowledges. MOVE_ENTRY_TIMEOUT_EN adds
// an acknowledge timeout.
module move_entry
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 16,
  parameter int GO_HOLD_CYCLES     = 2,
  parameter int ACK_TIMEOUT_CYCLES = 64
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      key_press,
  input  cell_idx_t key_idx,
  input  board_t    xin_star,
  input  board_t    oin_star,
  input  logic      playing_game,
  output board_t    xin,
  output logic      Go,
  output logic      busy,
  output logic      key_reject,
  output logic      ack_timeout
);

  localparam int            GW      = $clog2(GO_HOLD_CYCLES + 1);
  localparam logic [GW-1:0] GO_LAST = GW'(GO_HOLD_CYCLES - 1);

  entry_state_t  state, state_next;
  board_t        xin_q, xin_next;
  logic [GW-1:0] go_cnt, go_cnt_next;
  logic          reject_q, reject_next;
  logic          key_level, press_pulse, release_pulse;
  logic          legal;
  logic          acked;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock         (clock),
    .reset         (reset),
    .key_press     (key_press),
    .level         (key_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  // Out-of-range indices map to an empty mask, so they must be excluded explicitly.
  assign legal = playing_game
              && (key_idx <= cell_idx_t'(NUM_CELLS - 1))
              && ((xin_star | oin_star) & cell_onehot(key_idx)) == '0;
  assign acked = (xin_star & xin_q) != '0;

`ifdef MOVE_ENTRY_TIMEOUT_EN
  localparam int            TW      = $clog2(ACK_TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt, to_cnt_next;
  logic          timeout_q, timeout_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt    <= to_cnt_next;
      timeout_q <= timeout_next;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      xin_q    <= '0;
      go_cnt   <= '0;
      reject_q <= 1'b0;
    end else begin
      state    <= state_next;
      xin_q    <= xin_next;
      go_cnt   <= go_cnt_next;
      reject_q <= reject_next;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next   = state;
    xin_next     = xin_q;
    go_cnt_next  = go_cnt;
    reject_next  = 1'b0;
`ifdef MOVE_ENTRY_TIMEOUT_EN
    to_cnt_next  = to_cnt;
    timeout_next = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (press_pulse) begin
          if (legal) begin
            xin_next    = cell_onehot(key_idx);
            go_cnt_next = '0;
            state_next  = ISSUE;
          end else begin
            reject_next = 1'b1;
            state_next  = RELEASE;
          end
        end
      end
      ISSUE: begin
        if (go_cnt == GO_LAST) begin
          state_next = WAIT_ACK;
`ifdef MOVE_ENTRY_TIMEOUT_EN
          to_cnt_next = '0;
`endif
        end else begin
          go_cnt_next = go_cnt + 1'b1;
        end
      end
      WAIT_ACK: begin
        if (acked || !playing_game) begin
          xin_next   = '0;
          state_next = RELEASE;
        end
`ifdef MOVE_ENTRY_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          xin_next     = '0;
          timeout_next = 1'b1;
          state_next   = RELEASE;
        end else begin
          to_cnt_next = to_cnt + 1'b1;
        end
`endif
      end
      RELEASE: begin
        xin_next = '0;
        // Level check covers a key already released before RELEASE was reached.
        if (release_pulse || !key_level) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    xin        = xin_q;
    Go         = (state == ISSUE);
    busy       = (state != IDLE);
    key_reject = reject_q;
`ifdef MOVE_ENTRY_TIMEOUT_EN
    ack_timeout = timeout_q;
`else
    ack_timeout = 1'b0;
`endif
  end

endmodule

// File: tb/tb_move_entry.sv
// Self-checking bench for move_entry: table of press vectors plus hand-written
// bounce, reset, game-end and acknowledge-timeout sequences.
module tb_move_entry;
  import ttt_pkg::*;

  typedef struct {
    cell_idx_t idx;
    board_t    xs;
    board_t    os;
    logic      play;
    logic      legal;
    board_t    exp_xin;
  } vec_t;

  logic      clock = 1'b0;
  logic      reset = 1'b0;
  logic      key_press = 1'b0;
  cell_idx_t key_idx = '0;
  board_t    xin_star = '0;
  board_t    oin_star = '0;
  logic      playing_game = 1'b0;
  board_t    xin;
  logic      Go, busy, key_reject, ack_timeout;

  int     tests = 0;
  int     fails = 0;
  int     go_rises = 0;
  logic   go_prev = 1'b0;
  board_t exp_q[$];

  move_entry dut (
    .clock        (clock),
    .reset        (reset),
    .key_press    (key_press),
    .key_idx      (key_idx),
    .xin_star     (xin_star),
    .oin_star     (oin_star),
    .playing_game (playing_game),
    .xin          (xin),
    .Go           (Go),
    .busy         (busy),
    .key_reject   (key_reject),
    .ack_timeout  (ack_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: each Go burst must match the next queued move.
  always @(negedge clock) begin
    if (Go && !go_prev) begin
      go_rises++;
      check("go_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("go_xin", 32'(xin), 32'(exp_q.pop_front()));
    end
    go_prev = Go;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_measure(output int n);
    key_press = 1'b1;
    n = 0;
    while (!(Go || key_reject) && n < 40) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_go_low(output int n);
    n = 0;
    while (Go && n < 10) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic release_measure(output int n);
    key_press = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clock);
      n++;
    end
  endtask

  vec_t vecs[9];
  int   n, r;

  initial begin
    vecs[0] = '{idx: 4'd4,  xs: 9'h000, os: 9'h000, play: 1'b1, legal: 1'b1, exp_xin: 9'h010};
    vecs[1] = '{idx: 4'd0,  xs: 9'h000, os: 9'h001, play: 1'b1, legal: 1'b0, exp_xin: 9'h000};
    vecs[2] = '{idx: 4'd9,  xs: 9'h000, os: 9'h000, play: 1'b1, legal: 1'b0, exp_xin: 9'h000};
    vecs[3] = '{idx: 4'd3,  xs: 9'h000, os: 9'h000, play: 1'b0, legal: 1'b0, exp_xin: 9'h000};
    vecs[4] = '{idx: 4'd8,  xs: 9'h0FF, os: 9'h000, play: 1'b1, legal: 1'b1, exp_xin: 9'h100};
    vecs[5] = '{idx: 4'd5,  xs: 9'h020, os: 9'h000, play: 1'b1, legal: 1'b0, exp_xin: 9'h000};
    vecs[6] = '{idx: 4'd15, xs: 9'h000, os: 9'h000, play: 1'b1, legal: 1'b0, exp_xin: 9'h000};
    vecs[7] = '{idx: 4'd0,  xs: 9'h0AA, os: 9'h154, play: 1'b1, legal: 1'b1, exp_xin: 9'h001};
    vecs[8] = '{idx: 4'd2,  xs: 9'h000, os: 9'h1FB, play: 1'b1, legal: 1'b1, exp_xin: 9'h004};

    #1;
    check("rst_xin", 32'(xin), 32'h0);
    check("rst_go_busy", 32'({Go, busy}), 32'h0);
    check("rst_pulses", 32'({key_reject, ack_timeout}), 32'h0);
    cycles(3);
    reset = 1'b1;
    cycles(3);

    for (int i = 0; i < 9; i++) begin
      xin_star     = vecs[i].xs;
      oin_star     = vecs[i].os;
      playing_game = vecs[i].play;
      key_idx      = vecs[i].idx;
      if (vecs[i].legal) exp_q.push_back(vecs[i].exp_xin);
      press_measure(n);
      check($sformatf("v%0d_latency", i), 32'(n), 32'd18);
      if (vecs[i].legal) begin
        check($sformatf("v%0d_no_reject", i), 32'(key_reject), 32'd0);
        wait_go_low(n);
        check($sformatf("v%0d_go_len", i), 32'(n), 32'd2);
        check($sformatf("v%0d_xin_held", i), 32'(xin), 32'(vecs[i].exp_xin));
        xin_star = vecs[i].xs | vecs[i].exp_xin;
        key_idx  = 4'd7;
        @(negedge clock);
        check($sformatf("v%0d_ack_clear", i), 32'({xin, busy}), 32'h001);
        r = go_rises;
        cycles(25);
        check($sformatf("v%0d_no_repeat", i), 32'(go_rises - r), 32'd0);
      end else begin
        check($sformatf("v%0d_reject", i), 32'({key_reject, Go}), 32'h2);
        @(negedge clock);
        check($sformatf("v%0d_reject_1cyc", i), 32'({key_reject, xin, busy}), 32'h001);
        r = go_rises;
        cycles(10);
        check($sformatf("v%0d_no_go", i), 32'(go_rises - r), 32'd0);
      end
      release_measure(n);
      check($sformatf("v%0d_release", i), 32'(n), 32'd18);
      cycles(2);
    end

    // Bouncing key: only the final stable level yields a single move.
    xin_star = '0; oin_star = '0; playing_game = 1'b1; key_idx = 4'd1;
    exp_q.push_back(9'h002);
    r = go_rises;
    for (int i = 0; i < 12; i++) begin
      key_press = ~key_press;
      cycles(5);
    end
    press_measure(n);
    check("bounce_latency", 32'(n), 32'd18);
    wait_go_low(n);
    xin_star = 9'h002;
    @(negedge clock);
    release_measure(n);
    check("bounce_one_go", 32'(go_rises - r), 32'd1);
    cycles(2);

    // Game ends while waiting for acknowledge.
    xin_star = '0; key_idx = 4'd6;
    exp_q.push_back(9'h040);
    press_measure(n);
    wait_go_low(n);
    playing_game = 1'b0;
    @(negedge clock);
    check("game_end_clear", 32'({xin, busy}), 32'h001);
    release_measure(n);
    check("game_end_release", 32'(n), 32'd18);
    playing_game = 1'b1;
    cycles(2);

    // Reset one cycle into ISSUE.
    key_idx = 4'd3;
    exp_q.push_back(9'h008);
    press_measure(n);
    check("rstmid_go_seen", 32'(Go), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rstmid_outputs", 32'({xin, Go, busy}), 32'h0);
    key_press = 1'b0;
    cycles(3);
    reset = 1'b1;
    r = go_rises;
    cycles(40);
    check("rstmid_no_go", 32'(go_rises - r), 32'd0);
    exp_q.push_back(9'h008);
    press_measure(n);
    check("rstmid_fresh_press", 32'(n), 32'd18);
    wait_go_low(n);
    xin_star = 9'h008;
    @(negedge clock);
    release_measure(n);
    cycles(2);

    // Acknowledge never arrives.
    xin_star = '0; key_idx = 4'd2;
    exp_q.push_back(9'h004);
    press_measure(n);
    wait_go_low(n);
`ifdef MOVE_ENTRY_TIMEOUT_EN
    n = 0;
    while (!ack_timeout && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("timeout_latency", 32'(n), 32'd64);
    check("timeout_xin", 32'(xin), 32'h0);
    @(negedge clock);
    check("timeout_1cyc", 32'(ack_timeout), 32'd0);
`else
    cycles(200);
    check("no_timeout_xin", 32'(xin), 32'h004);
    check("no_timeout_flags", 32'({ack_timeout, busy}), 32'h1);
    xin_star = 9'h004;
    @(negedge clock);
`endif
    release_measure(n);
    check("final_idle", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
